// File: rtl/barrelshifter_pkg.sv
// Shared types for the iterative barrel shifter.
//   op_e    : operation encoding (ROR/ROL ignore op[0], so only the even code is named)
//   state_e : sequencer states of barrelshifter_iter
package barrelshifter_pkg;

   typedef enum logic [2:0] {
      OP_SRL = 3'b000,
      OP_SRA = 3'b001,
      OP_ROR = 3'b010,
      OP_SLL = 3'b100,
      OP_SLA = 3'b101,
      OP_ROL = 3'b110
   } op_e;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_e;

endpackage

// File: rtl/barrelshifter_step.sv
// Combinational single-bit shift/rotate step.
//   w        in   D_SIZE  working value
//   op       in   3       operation (see barrelshifter_pkg::op_e; op[0] ignored for ROR/ROL)
//   w_next   out  D_SIZE  value after one 1-bit step
//   ovf_step out  1       SLA only: sign bit differs from the bit shifted into it
module barrelshifter_step
   import barrelshifter_pkg::*;
#(
   parameter int unsigned D_SIZE = 8
) (
   input  logic [D_SIZE-1:0] w,
   input  logic [2:0]        op,
   output logic [D_SIZE-1:0] w_next,
   output logic              ovf_step
);

   logic [D_SIZE-1:0] sll;

   assign sll = {w[D_SIZE-2:0], 1'b0};

   always_comb begin
      w_next   = w;
      ovf_step = 1'b0;
      casez (op)
         OP_SRL:  w_next = {1'b0, w[D_SIZE-1:1]};
         OP_SRA:  w_next = {w[D_SIZE-1], w[D_SIZE-1:1]};
         3'b01?:  w_next = {w[0], w[D_SIZE-1:1]};
         OP_SLL:  w_next = sll;
         OP_SLA: begin
            // Sign bit is pinned; the bit below it is what gets lost on overflow.
            w_next   = {w[D_SIZE-1], sll[D_SIZE-2:0]};
            ovf_step = w[D_SIZE-2] ^ w[D_SIZE-1];
         end
         3'b11?:  w_next = {w[D_SIZE-2:0], w[D_SIZE-1]};
         default: w_next = w;
      endcase
   end

endmodule

// File: rtl/barrelshifter_iter.sv
// Bit-serial shift/rotate unit with valid/ready request and response handshakes.
// One 1-bit step per clock; response appears s_in+1 cycles after the request is accepted.
//   clk_in         in   1               clock
//   rst_n_in       in   1               asynchronous active-low reset
//   req_valid_in   in   1               request valid
//   req_ready_out  out  1               ready for a request (IDLE only)
//   x_in           in   D_SIZE          operand
//   s_in           in   $clog2(D_SIZE)  shift/rotate amount
//   op_in          in   3               operation
//   rsp_valid_out  out  1               response valid
//   rsp_ready_in   in   1               response accepted
//   y_out          out  D_SIZE          result
//   zf_out         out  1               result is zero
//   vf_out         out  1               sticky SLA overflow
module barrelshifter_iter
   import barrelshifter_pkg::*;
#(
   parameter int unsigned D_SIZE = 8
) (
   input  logic                      clk_in,
   input  logic                      rst_n_in,
   input  logic                      req_valid_in,
   output logic                      req_ready_out,
   input  logic [D_SIZE-1:0]         x_in,
   input  logic [$clog2(D_SIZE)-1:0] s_in,
   input  logic [2:0]                op_in,
   output logic                      rsp_valid_out,
   input  logic                      rsp_ready_in,
   output logic [D_SIZE-1:0]         y_out,
   output logic                      zf_out,
   output logic                      vf_out
);

   localparam int unsigned S_W = $clog2(D_SIZE);

   state_e            state;
   logic [S_W-1:0]    cnt;
   logic [D_SIZE-1:0] w;
   logic [2:0]        op;
   logic              vf_acc;
   logic [D_SIZE-1:0] w_next;
   logic              ovf_step;

   barrelshifter_step #(
      .D_SIZE (D_SIZE)
   ) u_step (
      .w        (w),
      .op       (op),
      .w_next   (w_next),
      .ovf_step (ovf_step)
   );

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state         <= IDLE;
         cnt           <= '0;
         w             <= '0;
         op            <= '0;
         vf_acc        <= 1'b0;
         req_ready_out <= 1'b0;
         rsp_valid_out <= 1'b0;
         y_out         <= '0;
         zf_out        <= 1'b0;
         vf_out        <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               req_ready_out <= 1'b1;
               if (req_valid_in && req_ready_out) begin
                  w             <= x_in;
                  op            <= op_in;
                  cnt           <= s_in;
                  vf_acc        <= 1'b0;
                  req_ready_out <= 1'b0;
                  state         <= (s_in == '0) ? DONE : SHIFT;
               end
            end
            SHIFT: begin
               w      <= w_next;
               vf_acc <= vf_acc | ovf_step;
               cnt    <= cnt - 1'b1;
               if (cnt == S_W'(1)) begin
                  state <= DONE;
               end
            end
            DONE: begin
               // First DONE cycle publishes the result; later cycles wait for the consumer.
               if (!rsp_valid_out) begin
                  rsp_valid_out <= 1'b1;
                  y_out         <= w;
                  zf_out        <= (w == '0);
                  vf_out        <= vf_acc;
               end else if (rsp_ready_in) begin
                  rsp_valid_out <= 1'b0;
                  req_ready_out <= 1'b1;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
